// File: rtl/elevator_pkg.sv
// Shared state encoding and direction constants for the SCAN elevator controller.
package elevator_pkg;
  typedef enum logic [1:0] {IDLE, DOOR_OPEN, MOVE} state_t;
  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;
endpackage

// File: rtl/elevator_call_scan.sv
// Combinational reduction of pending calls relative to a floor and direction:
// calls here (same/opposite sense) and calls strictly ahead/behind.
module elevator_call_scan
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 4,
  localparam int FW = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pend_car,
  input  logic [NUM_FLOORS-1:0] pend_up,
  input  logic [NUM_FLOORS-1:0] pend_dn,
  input  logic [FW-1:0]         floor,
  input  logic                  dir,
  output logic                  here_d,
  output logic                  here_o,
  output logic                  ahead,
  output logic                  behind
);
  logic [NUM_FLOORS-1:0] any_call, above, below;

  always_comb begin
    any_call = pend_car | pend_up | pend_dn;
    above    = '0;
    below    = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above[i] = any_call[i] && (FW'(i) > floor);
      below[i] = any_call[i] && (FW'(i) < floor);
    end
  end

  assign ahead  = (dir == UP) ? |above : |below;
  assign behind = (dir == UP) ? |below : |above;
  assign here_d = pend_car[floor] | ((dir == UP) ? pend_up[floor] : pend_dn[floor]);
  assign here_o = (dir == UP) ? pend_dn[floor] : pend_up[floor];
endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator controller: latches car/hall calls and owns the move and door timers.
// A latched call reaches door/moving one cycle later; one floor transit is MOVE_CYCLES cycles.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = 4,
  parameter int MOVE_CYCLES = 100_000_000,
  parameter int DOOR_CYCLES = 300_000_000,
  localparam int FW = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic [NUM_FLOORS-1:0] hall_up,
  input  logic [NUM_FLOORS-1:0] hall_dn,
  input  logic                  openDoor,
  input  logic                  closeDoor,
  output logic [FW-1:0]         floor,
  output logic                  dir,
  output logic                  door,
  output logic                  moving,
  output logic [NUM_FLOORS-1:0] pend_car,
  output logic [NUM_FLOORS-1:0] pend_up,
  output logic [NUM_FLOORS-1:0] pend_dn
);
  localparam int MTW = $clog2(MOVE_CYCLES + 1);
  localparam int DTW = $clog2(DOOR_CYCLES + 1);
  localparam logic [MTW-1:0]        MOVE_RELOAD = MTW'(MOVE_CYCLES - 1);
  localparam logic [DTW-1:0]        DOOR_RELOAD = DTW'(DOOR_CYCLES - 1);
  localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);
  localparam logic [FW-1:0]         TOP = FW'(NUM_FLOORS - 1);

  state_t                state, state_nxt;
  logic [FW-1:0]         floor_nxt, nf, scan_floor;
  logic                  dir_nxt, dir_arr, scan_dir, arriving;
  logic [MTW-1:0]        move_tmr, move_tmr_nxt;
  logic [DTW-1:0]        door_tmr, door_tmr_nxt;
  logic [NUM_FLOORS-1:0] up_in, dn_in, fmask, clr_car, clr_up, clr_dn;
  logic                  serve, call_here, here_d, here_o, ahead, behind;

  assign up_in     = hall_up & ~(ONE << (NUM_FLOORS - 1));
  assign dn_in     = hall_dn & ~ONE;
  assign fmask     = ONE << floor;
  assign nf        = (dir == UP) ? floor + FW'(1) : floor - FW'(1);
  assign dir_arr   = (nf == '0) ? UP : (nf == TOP) ? DOWN : dir;
  assign arriving  = (state == MOVE) && (move_tmr == '0);
  // On the arrival cycle the scan evaluates the floor being entered.
  assign scan_floor = arriving ? nf : floor;
  assign scan_dir   = arriving ? dir_arr : dir;
  assign call_here  = car_req[floor] | ((dir == UP) ? up_in[floor] : dn_in[floor]);

  elevator_call_scan #(.NUM_FLOORS(NUM_FLOORS)) u_scan (
    .pend_car (pend_car),
    .pend_up  (pend_up),
    .pend_dn  (pend_dn),
    .floor    (scan_floor),
    .dir      (scan_dir),
    .here_d   (here_d),
    .here_o   (here_o),
    .ahead    (ahead),
    .behind   (behind)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      floor    <= '0;
      dir      <= UP;
      move_tmr <= '0;
      door_tmr <= '0;
      pend_car <= '0;
      pend_up  <= '0;
      pend_dn  <= '0;
    end else begin
      state    <= state_nxt;
      floor    <= floor_nxt;
      dir      <= dir_nxt;
      move_tmr <= move_tmr_nxt;
      door_tmr <= door_tmr_nxt;
      pend_car <= (pend_car | car_req) & ~clr_car;
      pend_up  <= (pend_up | up_in) & ~clr_up;
      pend_dn  <= (pend_dn | dn_in) & ~clr_dn;
    end
  end

  always_comb begin
    state_nxt    = state;
    floor_nxt    = floor;
    dir_nxt      = dir;
    move_tmr_nxt = move_tmr;
    door_tmr_nxt = door_tmr;
    serve        = 1'b0;
    case (state)
      IDLE: begin
        if (openDoor || here_d) begin
          state_nxt    = DOOR_OPEN;
          door_tmr_nxt = DOOR_RELOAD;
          serve        = 1'b1;
        end else if (ahead) begin
          state_nxt    = MOVE;
          move_tmr_nxt = MOVE_RELOAD;
        end else if (here_o) begin
          dir_nxt      = ~dir;
          state_nxt    = DOOR_OPEN;
          door_tmr_nxt = DOOR_RELOAD;
          serve        = 1'b1;
        end else if (behind) begin
          dir_nxt = ~dir;
        end
      end
      DOOR_OPEN: begin
        serve = 1'b1;
        if (openDoor || call_here) begin
          door_tmr_nxt = DOOR_RELOAD;
        end else if (closeDoor || door_tmr == '0) begin
          door_tmr_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          door_tmr_nxt = door_tmr - DTW'(1);
        end
      end
      MOVE: begin
        if (!arriving) begin
          move_tmr_nxt = move_tmr - MTW'(1);
        end else begin
          floor_nxt = nf;
          dir_nxt   = dir_arr;
          if (here_d || (!ahead && here_o)) state_nxt = IDLE;
          else move_tmr_nxt = MOVE_RELOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Clearing follows the direction the door opens with, including a same-cycle flip.
  assign clr_car = serve ? fmask : '0;
  assign clr_up  = (serve && dir_nxt == UP) ? fmask : '0;
  assign clr_dn  = (serve && dir_nxt == DOWN) ? fmask : '0;

  always_comb begin
    door   = (state == DOOR_OPEN);
    moving = (state == MOVE);
  end
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed plan scenarios plus randomized traffic, checked every cycle against a behavioural model.
module tb_elevator_scan_ctrl;
  localparam int NF = 4;
  localparam int MC = 4;
  localparam int DC = 8;
  localparam int FW = $clog2(NF);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NF-1:0] car_req = '0, hall_up = '0, hall_dn = '0;
  logic          openDoor = 1'b0, closeDoor = 1'b0;
  logic [FW-1:0] floor;
  logic          dir, door, moving;
  logic [NF-1:0] pend_car, pend_up, pend_dn;

  int n_vec = 0;
  int n_err = 0;

  elevator_scan_ctrl #(.NUM_FLOORS(NF), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .car_req(car_req), .hall_up(hall_up), .hall_dn(hall_dn),
    .openDoor(openDoor), .closeDoor(closeDoor), .floor(floor), .dir(dir), .door(door),
    .moving(moving), .pend_car(pend_car), .pend_up(pend_up), .pend_dn(pend_dn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: car position, door/travel countdowns in whole cycles, call sets.
  int            m_floor, m_left, m_travel;
  bit            m_dir, m_door, m_moving, m_valid;
  bit [NF-1:0]   m_pc, m_pu, m_pd;

  function automatic bit m_any(int i);
    return m_pc[i] | m_pu[i] | m_pd[i];
  endfunction
  function automatic bit m_beyond(int f, bit up_dir);
    bit r = 1'b0;
    for (int i = 0; i < NF; i++)
      if (m_any(i) && (up_dir ? (i > f) : (i < f))) r = 1'b1;
    return r;
  endfunction
  function automatic bit m_here_d(int f, bit d);
    return m_pc[f] | (d ? m_pu[f] : m_pd[f]);
  endfunction
  function automatic bit m_here_o(int f, bit d);
    return d ? m_pd[f] : m_pu[f];
  endfunction

  always @(posedge clk) begin : model_blk
    bit [NF-1:0] nc, nu, nd;
    bit serve;
    nc = car_req; nu = hall_up; nd = hall_dn;
    nu[NF-1] = 1'b0;
    nd[0] = 1'b0;
    if (!reset) begin
      m_floor = 0; m_dir = 1'b1; m_door = 1'b0; m_moving = 1'b0;
      m_pc = '0; m_pu = '0; m_pd = '0; m_left = 0; m_travel = 0; m_valid = 1'b1;
    end else begin
      serve = 1'b0;
      if (m_door) begin
        serve = 1'b1;
        if (openDoor || nc[m_floor] || (m_dir ? nu[m_floor] : nd[m_floor])) m_left = DC;
        else if (closeDoor) m_door = 1'b0;
        else begin
          m_left--;
          if (m_left == 0) m_door = 1'b0;
        end
      end else if (m_moving) begin
        m_travel++;
        if (m_travel == MC) begin
          m_travel = 0;
          m_floor = m_dir ? m_floor + 1 : m_floor - 1;
          if (m_floor == 0) m_dir = 1'b1;
          else if (m_floor == NF - 1) m_dir = 1'b0;
          if (m_here_d(m_floor, m_dir) ||
              (!m_beyond(m_floor, m_dir) && m_here_o(m_floor, m_dir))) m_moving = 1'b0;
        end
      end else begin
        if (openDoor || m_here_d(m_floor, m_dir)) serve = 1'b1;
        else if (m_beyond(m_floor, m_dir)) begin
          m_moving = 1'b1;
          m_travel = 0;
        end else if (m_here_o(m_floor, m_dir)) begin
          m_dir = !m_dir;
          serve = 1'b1;
        end else if (m_beyond(m_floor, !m_dir)) m_dir = !m_dir;
        if (serve) begin
          m_door = 1'b1;
          m_left = DC;
        end
      end
      m_pc |= nc; m_pu |= nu; m_pd |= nd;
      if (serve) begin
        m_pc[m_floor] = 1'b0;
        if (m_dir) m_pu[m_floor] = 1'b0;
        else m_pd[m_floor] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("floor",    32'(floor),    32'(m_floor));
      chk("dir",      32'(dir),      32'(m_dir));
      chk("door",     32'(door),     32'(m_door));
      chk("moving",   32'(moving),   32'(m_moving));
      chk("pend_car", 32'(pend_car), 32'(m_pc));
      chk("pend_up",  32'(pend_up),  32'(m_pu));
      chk("pend_dn",  32'(pend_dn),  32'(m_pd));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit cond(input int what);
    case (what)
      0: return door == 1'b1;
      1: return door == 1'b0 && moving == 1'b0;
      2: return moving == 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int what, input int limit, input string nm);
    int n = 0;
    while (!cond(what) && n < limit) begin
      tick(1);
      n++;
    end
    if (!cond(what)) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: condition not reached within %0d cycles", nm, limit);
    end
  endtask

  function automatic logic [NF-1:0] rnd_call();
    logic [NF-1:0] v = '0;
    if ($urandom_range(0, 7) == 0) v[$urandom_range(0, NF - 1)] = 1'b1;
    return v;
  endfunction

  initial begin
    // 1: reset state and a single trip to floor 2
    tick(2);
    reset = 1'b1;
    chk("rst_floor", 32'(floor), 0); chk("rst_dir", 32'(dir), 1);
    chk("rst_door", 32'(door), 0);   chk("rst_moving", 32'(moving), 0);
    chk("rst_pend", 32'({pend_car, pend_up, pend_dn}), 0);
    car_req = 4'b0100; tick(1); car_req = '0;
    chk("s1_latch", 32'(pend_car), 32'h4); chk("s1_not_yet", 32'(moving), 0);
    tick(1); chk("s1_move_lat", 32'(moving), 1);
    tick(4); chk("s1_floor1", 32'(floor), 1);
    tick(4); chk("s1_floor2", 32'(floor), 2); chk("s1_stopped", 32'(moving), 0);
    tick(1); chk("s1_door", 32'(door), 1); chk("s1_pend_clr", 32'(pend_car), 0);
    tick(7); chk("s1_door_last", 32'(door), 1);
    tick(1); chk("s1_door_shut", 32'(door), 0);

    // 2: collective stop at 1 going up, then top floor with forced DOWN
    reset = 1'b0; tick(1); reset = 1'b1;
    hall_dn = 4'b1000; hall_up = 4'b0010; tick(1); hall_dn = '0; hall_up = '0;
    wait_for(0, 40, "s2_stop1");
    chk("s2_floor1", 32'(floor), 1); chk("s2_dir1", 32'(dir), 1);
    chk("s2_up_clr", 32'(pend_up), 0); chk("s2_dn_kept", 32'(pend_dn), 32'h8);
    wait_for(1, 40, "s2_close1");
    wait_for(0, 60, "s2_stop3");
    chk("s2_floor3", 32'(floor), 3); chk("s2_dir3", 32'(dir), 0); chk("s2_dn_clr", 32'(pend_dn), 0);

    // 3: door hold, release timing, close button
    wait_for(1, 40, "s3_close0");
    car_req = 4'b0100; tick(1); car_req = '0;
    wait_for(0, 40, "s3_stop2"); chk("s3_floor2", 32'(floor), 2);
    openDoor = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("s3_hold", 32'(door), 1);
    end
    openDoor = 1'b0;
    tick(7); chk("s3_release7", 32'(door), 1);
    tick(1); chk("s3_release8", 32'(door), 0);
    tick(2);
    openDoor = 1'b1; tick(1); openDoor = 1'b0;
    chk("s3_reopen", 32'(door), 1);
    closeDoor = 1'b1; tick(1); closeDoor = 1'b0;
    chk("s3_close_btn", 32'(door), 0);

    // 4: mid-transit pickup going up; opposite call served on the return
    car_req = 4'b0010; tick(1); car_req = '0;
    wait_for(0, 40, "s4_at1"); chk("s4_floor1", 32'(floor), 1);
    wait_for(1, 40, "s4_close1");
    car_req = 4'b1000; tick(1); car_req = '0;
    wait_for(2, 10, "s4_depart");
    tick(1); hall_up = 4'b0100; tick(1); hall_up = '0;
    wait_for(0, 40, "s4_stop2");
    chk("s4_floor2", 32'(floor), 2); chk("s4_dir2", 32'(dir), 1);
    chk("s4_up_clr", 32'(pend_up), 0); chk("s4_car3_kept", 32'(pend_car), 32'h8);
    wait_for(1, 40, "s4_close2");
    wait_for(0, 40, "s4_at3"); chk("s4_floor3", 32'(floor), 3);
    wait_for(1, 40, "s4_close3");
    car_req = 4'b0001; tick(1); car_req = '0;
    wait_for(0, 60, "s4_at0"); chk("s4_floor0", 32'(floor), 0);
    wait_for(1, 40, "s4_close0");
    car_req = 4'b1000; hall_dn = 4'b0100; tick(1); car_req = '0; hall_dn = '0;
    wait_for(0, 60, "s4_pass2");
    chk("s4_top", 32'(floor), 3); chk("s4_dn2_kept", 32'(pend_dn), 32'h4);
    wait_for(1, 40, "s4_close_top");
    wait_for(0, 40, "s4_return2");
    chk("s4_ret_floor", 32'(floor), 2); chk("s4_ret_dir", 32'(dir), 0);
    chk("s4_dn2_clr", 32'(pend_dn), 0);
    wait_for(1, 40, "s4_close_ret");

    // 5: reset mid-move
    car_req = 4'b0001; tick(1); car_req = '0;
    wait_for(2, 10, "s5_depart");
    hall_up = 4'b0010; tick(1); hall_up = '0; tick(1);
    reset = 1'b0; tick(1);
    chk("s5_floor", 32'(floor), 0); chk("s5_moving", 32'(moving), 0);
    chk("s5_dir", 32'(dir), 1); chk("s5_door", 32'(door), 0);
    chk("s5_pend", 32'({pend_car, pend_up, pend_dn}), 0);
    reset = 1'b1;

    // 6: ignored end-floor hall bits
    hall_up = 4'b1000; hall_dn = 4'b0001; tick(1); hall_up = '0; hall_dn = '0;
    tick(3);
    chk("s6_pend", 32'({pend_up, pend_dn}), 0);
    chk("s6_moving", 32'(moving), 0); chk("s6_floor", 32'(floor), 0);

    // randomized traffic, including occasional resets
    for (int c = 0; c < 4000; c++) begin
      car_req   = rnd_call();
      hall_up   = rnd_call();
      hall_dn   = rnd_call();
      openDoor  = ($urandom_range(0, 29) == 0);
      closeDoor = ($urandom_range(0, 9) == 0);
      reset     = !($urandom_range(0, 999) == 0);
      tick(1);
    end
    car_req = '0; hall_up = '0; hall_dn = '0; openDoor = 1'b0; closeDoor = 1'b0; reset = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
